// File: rtl/inst_fetch_seq_if.sv
// Fetch-sequencer bus: memory read port, decoder length loop,
// instruction hand-off to execute and redirect requests.
interface inst_fetch_seq_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [7:0]  dec_opcode;
    logic [1:0]  dec_inst_len;
    logic        inst_valid;
    logic [15:0] inst_pc;
    logic [15:0] inst_operand;
    logic [1:0]  inst_len;
    logic        inst_ack;
    logic        redir_valid;
    logic [15:0] redir_pc;

    modport master (
        output mem_addr, mem_rd, dec_opcode,
        output inst_valid, inst_pc, inst_operand, inst_len,
        input  mem_rdata, mem_ready, dec_inst_len,
        input  inst_ack, redir_valid, redir_pc
    );

    modport slave (
        input  mem_addr, mem_rd, dec_opcode,
        input  inst_valid, inst_pc, inst_operand, inst_len,
        output mem_rdata, mem_ready, dec_inst_len,
        output inst_ack, redir_valid, redir_pc
    );
endinterface

// File: rtl/inst_fetch_seq.sv
// Instruction fetch sequencer: reset vector load, opcode/operand
// fetch, instruction hold for execute and redirect handling.
module inst_fetch_seq #(
    parameter logic [15:0] VEC_ADDR = 16'hFFFC
) (
    input  logic            clk,
    input  logic            rst_n,
    inst_fetch_seq_if.master bus
);

    typedef enum logic [2:0] {
        RST, VEC_LO, VEC_HI, OP, OPR_LO, OPR_HI, HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q;
    logic        lo_first_q;
    logic [7:0]  opc_q;
    logic [15:0] ipc_q;
    logic [15:0] opr_q;
    logic [1:0]  len_q;
    logic [1:0]  len_samp;
    logic [1:0]  len_eff;
    logic [15:0] addr;
    logic        rd;
    logic        redir;
    logic        done;

    assign len_samp = (bus.dec_inst_len == 2'd0) ? 2'd1 : bus.dec_inst_len;
    // length only trusted from the decoder on the OPR_LO entry cycle
    assign len_eff  = lo_first_q ? len_samp : len_q;

    assign redir = bus.redir_valid &&
                   (state_q == OP || state_q == OPR_LO ||
                    state_q == OPR_HI || state_q == HOLD);
    assign done  = rd && bus.mem_ready && !redir;

    always_comb begin
        state_d = state_q;
        rd      = 1'b0;
        addr    = pc_q;
        unique case (state_q)
            RST: begin
                addr    = VEC_ADDR;
                state_d = VEC_LO;
            end
            VEC_LO: begin
                rd   = 1'b1;
                addr = VEC_ADDR;
                if (bus.mem_ready) state_d = VEC_HI;
            end
            VEC_HI: begin
                rd   = 1'b1;
                addr = VEC_ADDR + 16'd1;
                if (bus.mem_ready) state_d = OP;
            end
            OP: begin
                rd = 1'b1;
                if (bus.mem_ready) state_d = OPR_LO;
            end
            OPR_LO: begin
                if (len_eff < 2'd2) begin
                    state_d = HOLD;
                end else begin
                    rd = 1'b1;
                    if (bus.mem_ready)
                        state_d = (len_eff == 2'd3) ? OPR_HI : HOLD;
                end
            end
            OPR_HI: begin
                rd = 1'b1;
                if (bus.mem_ready) state_d = HOLD;
            end
            HOLD: begin
                if (bus.inst_ack) state_d = OP;
            end
            default: state_d = RST;
        endcase
        if (redir) state_d = OP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST;
            pc_q       <= 16'h0000;
            lo_first_q <= 1'b0;
            opc_q      <= 8'h00;
            ipc_q      <= 16'h0000;
            opr_q      <= 16'h0000;
            len_q      <= 2'd1;
        end else begin
            state_q    <= state_d;
            lo_first_q <= (state_d == OPR_LO) && (state_q != OPR_LO);
            if (state_q == OPR_LO && lo_first_q)
                len_q <= len_samp;
            if (redir) begin
                pc_q <= bus.redir_pc;
            end else if (done) begin
                if (state_q == VEC_LO) begin
                    pc_q[7:0] <= bus.mem_rdata;
                end else if (state_q == VEC_HI) begin
                    pc_q[15:8] <= bus.mem_rdata;
                end else if (state_q == OP) begin
                    opc_q <= bus.mem_rdata;
                    ipc_q <= pc_q;
                    opr_q <= 16'h0000;
                    pc_q  <= pc_q + 16'd1;
                end else if (state_q == OPR_LO) begin
                    opr_q[7:0] <= bus.mem_rdata;
                    pc_q       <= pc_q + 16'd1;
                end else if (state_q == OPR_HI) begin
                    opr_q[15:8] <= bus.mem_rdata;
                    pc_q        <= pc_q + 16'd1;
                end
            end
        end
    end

    assign bus.mem_addr     = addr;
    assign bus.mem_rd       = rd;
    assign bus.dec_opcode   = opc_q;
    assign bus.inst_valid   = (state_q == HOLD);
    assign bus.inst_pc      = ipc_q;
    assign bus.inst_operand = opr_q;
    assign bus.inst_len     = len_q;

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Directed plus randomized bench for inst_fetch_seq against a memory
// image, a decoder length table and an instruction-level model.
module tb_inst_fetch_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inst_fetch_seq_if dif ();

    inst_fetch_seq #(.VEC_ADDR(16'hFFFC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    logic [7:0]  mem [0:65535];
    logic [1:0]  len_tab [0:255];
    logic [15:0] mpc;
    int          nchecks = 0;
    int          nerr = 0;

    assign dif.mem_rdata    = mem[dif.mem_addr];
    assign dif.dec_inst_len = len_tab[dif.dec_opcode];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // RST -> vector low -> vector high -> first opcode read
    task automatic do_vector;
        dif.mem_ready = 1'b1;
        chk("rst_rd", dif.mem_rd, 0);
        chk("rst_valid", dif.inst_valid, 0);
        step;
        chk("vlo_rd", dif.mem_rd, 1);
        chk("vlo_addr", dif.mem_addr, 16'hFFFC);
        chk("vlo_valid", dif.inst_valid, 0);
        step;
        chk("vhi_rd", dif.mem_rd, 1);
        chk("vhi_addr", dif.mem_addr, 16'hFFFD);
        step;
        mpc = {mem[16'hFFFD], mem[16'hFFFC]};
        chk("op_rd", dif.mem_rd, 1);
        chk("op_addr", dif.mem_addr, mpc);
        chk("op_valid", dif.inst_valid, 0);
    endtask

    // Called in the OP entry cycle; runs one instruction to acceptance.
    task automatic run_inst(input int ack_dly, input int s0, input int s1,
                            input int s2, input bit rdr,
                            input logic [15:0] rpc);
        logic [7:0]  op;
        logic [15:0] a [3];
        logic [15:0] exp_opr;
        logic [15:0] nxt;
        int st [3];
        int len, ridx, stall, cyc, exp_lat;
        st[0] = s0; st[1] = s1; st[2] = s2;
        op = mem[mpc];
        len = int'(len_tab[op]);
        if (len == 0) len = 1;
        a[0] = mpc;
        a[1] = mpc + 16'd1;
        a[2] = mpc + 16'd2;
        exp_opr = {(len == 3) ? mem[a[2]] : 8'h00,
                   (len >= 2) ? mem[a[1]] : 8'h00};
        exp_lat = (len == 3) ? 3 : 2;
        for (int i = 0; i < len; i++) exp_lat += st[i];
        ridx = 0;
        stall = st[0];
        cyc = 0;
        dif.inst_ack = 1'b0;
        dif.redir_valid = 1'b0;
        while (dif.inst_valid !== 1'b1 && cyc < 60) begin
            if (dif.mem_rd === 1'b1) begin
                if (ridx < len) begin
                    chk("rd_addr", dif.mem_addr, a[ridx]);
                    if (stall > 0) begin
                        dif.mem_ready = 1'b0;
                        stall--;
                    end else begin
                        dif.mem_ready = 1'b1;
                        ridx++;
                        stall = (ridx < 3) ? st[ridx] : 0;
                    end
                end else begin
                    chk("extra_rd", dif.mem_rd, 0);
                    dif.mem_ready = 1'b1;
                end
            end else begin
                dif.mem_ready = 1'($urandom_range(0, 1));
            end
            step;
            cyc++;
        end
        chk("latency", cyc, exp_lat);
        chk("nreads", ridx, len);
        chk("inst_pc", dif.inst_pc, a[0]);
        chk("operand", dif.inst_operand, exp_opr);
        chk("inst_len", dif.inst_len, len);
        chk("opcode", dif.dec_opcode, op);
        for (int i = 0; i < ack_dly; i++) begin
            dif.mem_ready = 1'($urandom_range(0, 1));
            chk("hold_valid", dif.inst_valid, 1);
            chk("hold_rd", dif.mem_rd, 0);
            chk("hold_pc", dif.inst_pc, a[0]);
            chk("hold_opr", dif.inst_operand, exp_opr);
            step;
        end
        dif.inst_ack = 1'b1;
        if (rdr) begin
            dif.redir_valid = 1'b1;
            dif.redir_pc = rpc;
        end
        step;
        dif.inst_ack = 1'b0;
        dif.redir_valid = 1'b0;
        nxt = rdr ? rpc : mpc + 16'(len);
        chk("ack_valid", dif.inst_valid, 0);
        chk("next_rd", dif.mem_rd, 1);
        chk("next_addr", dif.mem_addr, nxt);
        mpc = nxt;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) len_tab[i] = 2'($urandom_range(0, 3));
        len_tab[8'hEA] = 2'd1;
        len_tab[8'hA9] = 2'd2;
        len_tab[8'h4C] = 2'd3;
        len_tab[8'hAD] = 2'd3;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
        mem[16'h8000] = 8'hEA;
        mem[16'h8001] = 8'hA9;
        mem[16'h8002] = 8'h05;
        mem[16'h8003] = 8'h4C;
        mem[16'h8004] = 8'h34;
        mem[16'h8005] = 8'h12;
        mem[16'h8006] = 8'hAD;
        mem[16'h8007] = 8'h00;
        mem[16'h8008] = 8'h20;
        mem[16'hA000] = 8'h4C;
        mem[16'hFFFE] = 8'h4C;

        rst_n = 1'b0;
        dif.mem_ready = 1'b0;
        dif.inst_ack = 1'b0;
        dif.redir_valid = 1'b0;
        dif.redir_pc = 16'h0000;
        mpc = 16'h0000;
        repeat (3) step;
        chk("r_rd", dif.mem_rd, 0);
        chk("r_addr", dif.mem_addr, 16'hFFFC);
        chk("r_opc", dif.dec_opcode, 0);
        chk("r_valid", dif.inst_valid, 0);
        chk("r_pc", dif.inst_pc, 0);
        chk("r_opr", dif.inst_operand, 0);
        chk("r_len", dif.inst_len, 1);
        rst_n = 1'b1;
        do_vector;

        run_inst(0, 0, 0, 0, 1'b0, 16'h0);
        run_inst(0, 0, 0, 0, 1'b0, 16'h0);
        run_inst(0, 0, 0, 0, 1'b0, 16'h0);
        run_inst(0, 0, 3, 0, 1'b0, 16'h0);
        run_inst(5, 0, 0, 0, 1'b0, 16'h0);

        for (int n = 0; n < 25; n++)
            run_inst($urandom_range(0, 3), $urandom_range(0, 2),
                     $urandom_range(0, 2), $urandom_range(0, 2),
                     1'b0, 16'h0);

        // redirect in OP while the opcode read completes
        dif.mem_ready = 1'b1;
        dif.redir_valid = 1'b1;
        dif.redir_pc = 16'hA000;
        step;
        dif.redir_valid = 1'b0;
        chk("rop_addr", dif.mem_addr, 16'hA000);
        chk("rop_rd", dif.mem_rd, 1);
        chk("rop_valid", dif.inst_valid, 0);

        // redirect in OPR_HI with a stalled read
        step;
        step;
        chk("rhi_addr", dif.mem_addr, 16'hA002);
        chk("rhi_rd", dif.mem_rd, 1);
        dif.mem_ready = 1'b0;
        dif.redir_valid = 1'b1;
        dif.redir_pc = 16'hC000;
        step;
        dif.redir_valid = 1'b0;
        chk("rhi_new", dif.mem_addr, 16'hC000);
        chk("rhi_valid", dif.inst_valid, 0);
        mpc = 16'hC000;
        run_inst(0, 0, 0, 0, 1'b1, 16'hC000);
        run_inst(2, 1, 0, 1, 1'b1, 16'hFFFE);
        run_inst(0, 0, 1, 1, 1'b0, 16'h0);
        chk("wrap_pc", mpc, 16'h0001);
        run_inst(1, 0, 0, 0, 1'b0, 16'h0);

        // asynchronous reset mid-OPR_LO
        dif.mem_ready = 1'b1;
        step;
        rst_n = 1'b0;
        #1;
        chk("mr_rd", dif.mem_rd, 0);
        chk("mr_addr", dif.mem_addr, 16'hFFFC);
        chk("mr_valid", dif.inst_valid, 0);
        chk("mr_len", dif.inst_len, 1);
        chk("mr_opc", dif.dec_opcode, 0);
        step;
        step;
        chk("mr_valid2", dif.inst_valid, 0);
        rst_n = 1'b1;
        do_vector;
        run_inst(0, 0, 0, 0, 1'b0, 16'h0);
        chk("post_rst_pc", mpc, 16'h8001);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
